imm_ext_queue: RTL and testbench

// - Registered, parametrised immediate extender for the 16-bit TSC-ISA multi-cycle CPU.
// - Decodes the immediate format from opcode instr[15:12] and produces a WORD_W-bit immediate.
// - Results go into a small in-order output queue behind a valid/ready handshake, so the IR stage can run ahead of a stalled EX stage.

---
 rtl/imm_ext_queue.sv | 138 +++++++++++++
 tb/tb_imm_ext_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_queue.sv
// Immediate extender for the 16-bit TSC-ISA CPU: decodes the immediate format
// from the opcode and queues {imm, fmt} results in a small in-order FIFO.
module imm_ext_queue #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_imm,
    output logic [2:0]        out_fmt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        FMT_NONE   = 3'd0,
        FMT_SEXT8  = 3'd1,
        FMT_ZEXT8  = 3'd2,
        FMT_HI8    = 3'd3,
        FMT_SEXT12 = 3'd4
    } fmt_e;

    fmt_e              dec_fmt;
    logic [WORD_W-1:0] dec_imm;

    logic [WORD_W-1:0] imm_mem_q [DEPTH];
    logic [WORD_W-1:0] imm_mem_d [DEPTH];
    logic [2:0]        fmt_mem_q [DEPTH];
    logic [2:0]        fmt_mem_d [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push;
    logic              pop;

    // Upper bits are filled first, then the low field overwrites them.
    always_comb begin
        dec_fmt = FMT_NONE;
        dec_imm = '0;
        case (in_instr[15:12])
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8: begin
                dec_fmt      = FMT_SEXT8;
                dec_imm      = {WORD_W{in_instr[7]}};
                dec_imm[7:0] = in_instr[7:0];
            end
            4'd5: begin
                dec_fmt      = FMT_ZEXT8;
                dec_imm[7:0] = in_instr[7:0];
            end
            4'd6: begin
                dec_fmt       = FMT_HI8;
                dec_imm       = {WORD_W{in_instr[7]}};
                dec_imm[15:0] = {in_instr[7:0], 8'h00};
            end
            4'd9, 4'd10: begin
                dec_fmt       = FMT_SEXT12;
                dec_imm       = {WORD_W{in_instr[11]}};
                dec_imm[11:0] = in_instr[11:0];
            end
            default: begin
                dec_fmt = FMT_NONE;
                dec_imm = '0;
            end
        endcase
    end

    // Handshake: a beat transfers on a rising edge where valid && ready are both
    // high; valid never depends on ready and ready never depends on valid.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm = out_valid ? imm_mem_q[rd_ptr_q] : '0;
    assign out_fmt = out_valid ? fmt_mem_q[rd_ptr_q] : 3'd0;

    always_comb begin
        imm_mem_d = imm_mem_q;
        fmt_mem_d = fmt_mem_q;
        if (push && !flush) begin
            imm_mem_d[wr_ptr_q] = dec_imm;
            fmt_mem_d[wr_ptr_q] = dec_fmt;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is unobservable while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        imm_mem_q <= imm_mem_d;
        fmt_mem_q <= fmt_mem_d;
    end

endmodule

// File: tb/tb_imm_ext_queue.sv
// Directed bench for imm_ext_queue: a 16-bit instance checked against an
// expected queue on every cycle, plus a 32-bit instance for wide extension.
module tb_imm_ext_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [2:0]  out_fmt;

    logic        in_valid32;
    logic        in_ready32;
    logic [15:0] in_instr32;
    logic        out_valid32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;

    int n_checks = 0;
    int n_errors = 0;
    int dut_pops = 0;

    logic [18:0] exp_q[$];
    logic [18:0] drv_exp;

    imm_ext_queue #(.WORD_W(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt)
    );

    imm_ext_queue #(.WORD_W(32), .DEPTH(DEPTH)) dut32 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (1'b0),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_instr  (in_instr32),
        .out_valid (out_valid32),
        .out_ready (1'b1),
        .out_imm   (out_imm32),
        .out_fmt   (out_fmt32)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode: returns {fmt, 32-bit sign/zero-extended immediate}.
    function automatic logic [34:0] model(input logic [15:0] i);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [11:0] j;
        int                 v;
        logic [2:0]         f;
        b = i[7:0];
        h = {i[7:0], 8'h00};
        j = i[11:0];
        case (i[15:12])
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8: begin f = 3'd1; v = b; end
            4'd5:                                     begin f = 3'd2; v = {24'h0, i[7:0]}; end
            4'd6:                                     begin f = 3'd3; v = h; end
            4'd9, 4'd10:                              begin f = 3'd4; v = j; end
            default:                                  begin f = 3'd0; v = 0; end
        endcase
        return {f, v};
    endfunction

    // Driver tasks: set inputs, then advance to just after the next rising edge.
    task automatic drive_x(input logic v, input logic [15:0] instr,
                           input logic [15:0] e_imm, input logic [2:0] e_fmt,
                           input logic rdy);
        in_valid  = v;
        in_instr  = instr;
        out_ready = rdy;
        drv_exp   = {e_fmt, e_imm};
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic rdy);
        logic [34:0] m;
        m = model(instr);
        drive_x(v, instr, m[15:0], m[34:32], rdy);
    endtask

    task automatic check32(input logic [15:0] instr, input logic [31:0] e_imm);
        in_valid32 = 1'b1;
        in_instr32 = instr;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        in_instr32 = 16'hFFFF;
        @(negedge clk);
        check("w32_valid", out_valid32, 1);
        check("w32_imm", out_imm32, e_imm);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare head every cycle, then predict the next edge.
    always @(negedge clk) begin
        int          cnt;
        logic [18:0] head;
        cnt = exp_q.size();
        if (reset_n) begin
            check("in_ready", in_ready, cnt < DEPTH);
            check("out_valid", out_valid, cnt != 0);
            if (cnt != 0) begin
                head = exp_q[0];
                check("out_imm", out_imm, head[15:0]);
                check("out_fmt", out_fmt, head[18:16]);
            end else begin
                check("empty_imm", out_imm, 0);
                check("empty_fmt", out_fmt, 0);
            end
            if (out_valid && out_ready && !flush) dut_pops++;
        end
        if (!reset_n || flush) begin
            exp_q.delete();
        end else begin
            if (cnt != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && cnt < DEPTH) exp_q.push_back(drv_exp);
        end
    end

    initial begin
        int pops0;
        reset_n    = 1'b0;
        flush      = 1'b0;
        in_valid32 = 1'b0;
        in_instr32 = 16'h0;
        drv_exp    = '0;

        // Reset held two cycles with in_valid high
        drive(1'b1, 16'h4401, 1'b0);
        drive(1'b1, 16'h4401, 1'b0);
        reset_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_in_ready", in_ready, 1);

        // Formats, one per cycle with the consumer always ready
        drive_x(1'b1, 16'h9801, 16'hF801, 3'd4, 1'b1);
        drive_x(1'b1, 16'h4480, 16'hFF80, 3'd1, 1'b1);
        drive_x(1'b1, 16'h5480, 16'h0080, 3'd2, 1'b1);
        drive_x(1'b1, 16'h6412, 16'h1200, 3'd3, 1'b1);
        drive_x(1'b1, 16'hF41C, 16'h0000, 3'd0, 1'b1);
        drive(1'b0, 16'h1234, 1'b1);
        drive(1'b0, 16'h5678, 1'b1);

        // Backpressure: fill, hold a third, then drain in order
        pops0 = dut_pops;
        drive_x(1'b1, 16'h4401, 16'h0001, 3'd1, 1'b0);
        drive_x(1'b1, 16'h4402, 16'h0002, 3'd1, 1'b0);
        check("bp_full_ready", in_ready, 0);
        drive_x(1'b1, 16'h4403, 16'h0003, 3'd1, 1'b0);
        drive_x(1'b1, 16'h4403, 16'h0003, 3'd1, 1'b0);
        drive_x(1'b1, 16'h4403, 16'h0003, 3'd1, 1'b1);
        drive_x(1'b1, 16'h4403, 16'h0003, 3'd1, 1'b1);
        drive_x(1'b0, 16'h4404, 16'h0004, 3'd1, 1'b1);
        drive_x(1'b0, 16'h4405, 16'h0005, 3'd1, 1'b1);
        check("bp_pop_count", dut_pops - pops0, 3);

        // Continuous push+pop at count 1
        drive(1'b1, 16'h7000 | 16'($urandom_range(0, 255)), 1'b1);
        pops0 = dut_pops;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), 1'b1);
            check("pp_valid", out_valid, 1);
        end
        check("pp_pop_count", dut_pops - pops0, 8);
        drive(1'b0, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 1'b1);

        // Flush with two queued and a same-cycle push
        drive(1'b1, 16'h4411, 1'b0);
        drive(1'b1, 16'h4412, 1'b0);
        flush = 1'b1;
        drive(1'b1, 16'h4455, 1'b1);
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        drive(1'b0, 16'h4455, 1'b0);
        drive(1'b1, 16'h4466, 1'b1);
        check("post_flush_imm", out_imm, 16'h0066);
        drive(1'b0, 16'h0000, 1'b1);
        check("post_flush_empty", out_valid, 0);
        drive(1'b0, 16'h0000, 1'b1);

        // Reset mid-stream with entries queued
        drive(1'b1, 16'h5421, 1'b0);
        drive(1'b1, 16'h5422, 1'b0);
        reset_n = 1'b0;
        drive(1'b1, 16'h5423, 1'b0);
        reset_n = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        drive(1'b0, 16'h0000, 1'b1);

        // Wide extension on the 32-bit instance
        check32(16'h4480, 32'hFFFFFF80);
        check32(16'h6480, 32'hFFFF8000);
        check32(16'hA7FF, 32'h000007FF);
        check32(16'hA800, 32'hFFFFF800);
        check("w32_empty", out_valid32, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
